// File: rtl/mem_bank_if.sv
// mem_bank_if: host request/response bundle for mem_bank
interface mem_bank_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 3
);
  logic sel, rw, clr, ready, busy, rdValid;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] wordIn, wordOut;
  modport master (output sel, rw, addr, wordIn, clr, input ready, busy, wordOut, rdValid);
  modport slave (input sel, rw, addr, wordIn, clr, output ready, busy, wordOut, rdValid);
endinterface

// File: rtl/mem_bank.sv
// mem_bank: DEPTH x WIDTH synchronous memory with ready handshake, registered reads and clear sweep
module mem_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH) < 1 ? 1 : $clog2(DEPTH),
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input logic clk,
  input logic rst_n,
  mem_bank_if.slave bus
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic acc, in_range;
  assign bus.ready = state == IDLE && !bus.clr;
  assign bus.busy = state == CLEAR;
  assign acc = bus.sel && bus.ready;
  assign in_range = {1'b0, bus.addr} < DEPTH_L;
  always_comb begin
    state_nxt = state;
    state_nxt = state == CLEAR ? (ptr == LAST ? IDLE : CLEAR) : (bus.clr ? CLEAR : IDLE);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
      bus.wordOut <= '0;
      bus.rdValid <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= bus.busy ? (ptr == LAST ? '0 : ptr + 1'b1) : '0;
      bus.rdValid <= acc && !bus.rw;
      if (acc && !bus.rw) bus.wordOut <= in_range ? mem[bus.addr] : '0;
    end
  // out-of-range addresses never reach the array: writes drop, reads return zero
  always_ff @(posedge clk)
    if (rst_n && bus.busy) mem[ptr] <= CLEAR_VAL;
    else if (acc && bus.rw && in_range) mem[bus.addr] <= bus.wordIn;
endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: scoreboard bench for an 8x8 bank and a 5x16 bank
module tb_mem_bank;
  logic clk = 1'b0, rst_n = 1'b0, rst_b_n = 1'b0;
  int n_run = 0, n_fail = 0, rv_a = 0, rv_b = 0;
  logic [7:0] mdl_a [8];
  logic [15:0] mdl_b [5];
  logic [7:0] q_a [$];
  logic [15:0] q_b [$];
  always #5 clk = ~clk;
  mem_bank_if #(.WIDTH(8), .ADDR_W(3)) ba ();
  mem_bank_if #(.WIDTH(16), .ADDR_W(3)) bb ();
  mem_bank #(.WIDTH(8), .DEPTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  mem_bank #(.WIDTH(16), .DEPTH(5)) dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bb));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ba.rdValid === 1'b1) begin
      rv_a++;
      if (q_a.size() == 0) chk("a_unexpected_rdvalid", 32'(ba.rdValid), 0);
      else chk("a_read", 32'(ba.wordOut), 32'(q_a.pop_front()));
    end
    if (bb.rdValid === 1'b1) begin
      rv_b++;
      if (q_b.size() == 0) chk("b_unexpected_rdvalid", 32'(bb.rdValid), 0);
      else chk("b_read", 32'(bb.wordOut), 32'(q_b.pop_front()));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ba.sel = 0; ba.rw = 0; ba.clr = 0;
    bb.sel = 0; bb.rw = 0; bb.clr = 0;
  endtask
  task automatic wait_clr(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(b ? "b_busy" : "a_busy", 32'(b ? bb.busy : ba.busy), 1);
      chk(b ? "b_not_ready" : "a_not_ready", 32'(b ? bb.ready : ba.ready), 0);
    end
    @(negedge clk);
    chk(b ? "b_busy_done" : "a_busy_done", 32'(b ? bb.busy : ba.busy), 0);
    chk(b ? "b_ready" : "a_ready", 32'(b ? bb.ready : ba.ready), 1);
    step();
  endtask
  task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
    chk("a_wr_ready", 32'(ba.ready), 1);
    ba.sel = 1; ba.rw = 1; ba.addr = a; ba.wordIn = d; mdl_a[a] = d;
    step();
  endtask
  task automatic rd_a(input logic [2:0] a);
    chk("a_rd_ready", 32'(ba.ready), 1);
    ba.sel = 1; ba.rw = 0; ba.addr = a; q_a.push_back(mdl_a[a]);
    step();
  endtask
  task automatic wr_b(input logic [2:0] a, input logic [15:0] d);
    bb.sel = 1; bb.rw = 1; bb.addr = a; bb.wordIn = d;
    if (a < 5) mdl_b[a] = d;
    step();
  endtask
  task automatic rd_b(input logic [2:0] a);
    bb.sel = 1; bb.rw = 0; bb.addr = a; q_b.push_back(a < 5 ? mdl_b[a] : 16'h0);
    step();
  endtask
  initial begin
    idle();
    ba.addr = 0; ba.wordIn = 0; bb.addr = 0; bb.wordIn = 0;
    for (int i = 0; i < 8; i++) mdl_a[i] = 0;
    for (int i = 0; i < 5; i++) mdl_b[i] = 0;
    step(); step();
    @(negedge clk);
    chk("a_rst_wordout", 32'(ba.wordOut), 0);
    chk("a_rst_rdvalid", 32'(ba.rdValid), 0);
    chk("a_rst_busy", 32'(ba.busy), 1);
    step();
    rst_n = 1;
    wait_clr(0, 8);
    for (int i = 0; i < 8; i++) rd_a(3'(i));
    idle();
    step();
    chk("t1_pulses", rv_a, 8);
    wr_a(3, 8'hAA);
    rd_a(3);
    idle();
    @(negedge clk);
    chk("t2_rdvalid_hi", 32'(ba.rdValid), 1);
    @(negedge clk);
    chk("t2_rdvalid_lo", 32'(ba.rdValid), 0);
    step();
    ba.sel = 0; ba.rw = 1; ba.addr = 3; ba.wordIn = 8'hF0;
    repeat (3) step();
    rd_a(3);
    wr_a(7, 8'hCC);
    rd_a(7);
    rd_a(0);
    idle();
    step();
    ba.clr = 1; ba.sel = 1; ba.rw = 1; ba.addr = 3; ba.wordIn = 8'h55;
    #1 chk("t5_ready_low", 32'(ba.ready), 0);
    step();
    idle();
    for (int i = 0; i < 8; i++) mdl_a[i] = 0;
    wait_clr(0, 8);
    chk("t5_wordout_held", 32'(ba.wordOut), 0);
    rd_a(3);
    rd_a(7);
    idle();
    step(); step();
    rst_b_n = 1;
    wait_clr(1, 5);
    wr_b(6, 16'hBEEF);
    wr_b(4, 16'h1234);
    rd_b(6);
    rd_b(4);
    idle();
    step();
    chk("t6_b_pulses", rv_b, 2);
    bb.clr = 1;
    step();
    bb.clr = 0;
    for (int i = 0; i < 5; i++) mdl_b[i] = 0;
    step(); step();
    rst_b_n = 0;
    step();
    rst_b_n = 1;
    chk("t6_rst_wordout", 32'(bb.wordOut), 0);
    wait_clr(1, 5);
    rd_b(4);
    idle();
    step(); step();
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
